uart_rx_8n1: RTL and testbench

- UART receiver, 8 data bits, no parity, 1 stop bit, LSB first; the receive-side counterpart of the existing uart_tx_8n1.
- Runs directly on the 25 MHz board clock and uses an internal bit-period counter, not a divided clock.
- Delivers each received byte with a one-cycle valid strobe, plus a framing-error strobe.
- Sits between the board RX pin and user logic, e.g. a loopback or command parser in top.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync2.sv | 29 ++
 rtl/uart_rx_8n1.sv | 158 +++++++++++++++
 tb/tb_uart_rx_8n1.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit timing and receiver state encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_CLKS_PER_BIT = 50;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high input; both stages reset to 1.
module sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with bit-period counter. Define UART_RX_MAJORITY_EN for 2-of-3
// majority sampling around each sample point (strobe then arrives one cycle later).
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx,
    output logic [7:0] rxbyte,
    output logic       rxvalid,
    output logic       frame_err,
    output logic       busy
);

`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned SMP_OFS = 1;
`else
    localparam int unsigned SMP_OFS = 0;
`endif

    // Decision points; with majority sampling they sit one count past the nominal target and
    // the counter reloads to 1 so the bit-period spacing stays the same.
    localparam logic [CNT_W-1:0] START_AT   = CNT_W'(CLKS_PER_BIT / 2 - 1 + SMP_OFS);
    localparam logic [CNT_W-1:0] BIT_AT     = CNT_W'(CLKS_PER_BIT - 1 + SMP_OFS);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SMP_OFS);
    localparam logic [2:0]       LAST_BIT   = 3'(UART_DATA_BITS - 1);

    logic rx_s;
    logic smp;

    uart_rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                bitidx_q, bitidx_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [UART_DATA_BITS-1:0] rxbyte_q, rxbyte_d;
    logic                      rxvalid_q, rxvalid_d;
    logic                      frame_err_q, frame_err_d;

    sync2 u_sync2 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx),
        .q_o   (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] is rx_s one cycle ago, hist_q[1] two cycles ago.
    logic [1:0] hist_q, hist_d;

    always_comb begin
        hist_d = {hist_q[0], rx_s};
        smp    = maj3(hist_q[1], hist_q[0], rx_s);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    assign smp = rx_s;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bitidx_d    = bitidx_q;
        shreg_d     = shreg_q;
        rxbyte_d    = rxbyte_q;
        rxvalid_d   = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == START_AT) begin
                    if (smp) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_DATA;
                        cnt_d    = CNT_RELOAD;
                        bitidx_d = '0;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_AT) begin
                    shreg_d[bitidx_q] = smp;
                    cnt_d             = CNT_RELOAD;
                    bitidx_d          = bitidx_q + 3'd1;
                    if (bitidx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_AT) begin
                    cnt_d = '0;
                    if (smp) begin
                        rxbyte_d  = shreg_q;
                        rxvalid_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold off until the line returns high so a stuck-low line cannot retrigger.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bitidx_q    <= '0;
            shreg_q     <= '0;
            rxbyte_q    <= '0;
            rxvalid_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitidx_q    <= bitidx_d;
            shreg_q     <= shreg_d;
            rxbyte_q    <= rxbyte_d;
            rxvalid_q   <= rxvalid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rxbyte    = rxbyte_q;
    assign rxvalid   = rxvalid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed self-checking bench for uart_rx_8n1 (majority scenario runs when
// UART_RX_MAJORITY_EN is defined).
module tb_uart_rx_8n1;

    localparam int N = 50;
    localparam int H = N / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 2 + H + 9 * N + 2;
`else
    localparam int LAT = 2 + H + 9 * N + 1;
`endif

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rxbyte;
    logic       rxvalid;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int         cyc = 0;
    logic [7:0] vq[$];
    int         vt[$];
    int         ecnt = 0;
    int         et = 0;
    int         busy_cnt = 0;
    int         both_cnt = 0;

    uart_rx_8n1 #(
        .CLKS_PER_BIT (N),
        .CNT_W        (16)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .rx        (rx),
        .rxbyte    (rxbyte),
        .rxvalid   (rxvalid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rxvalid) begin
            vq.push_back(rxbyte);
            vt.push_back(cyc);
        end
        if (frame_err) begin
            ecnt <= ecnt + 1;
            et   <= cyc;
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (rxvalid && frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(N);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, output int t_fall);
        t_fall = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        rx    = 1'b1;
        tick(3);
        rst_i = 1'b0;
        tick(2);
        total++;
        if (rxbyte !== 8'h00) begin
            bad++; $display("FAIL reset_rxbyte got=%h want=00", rxbyte);
        end
        total++;
        if (rxvalid !== 1'b0) begin
            bad++; $display("FAIL reset_rxvalid got=%b want=0", rxvalid);
        end
        total++;
        if (frame_err !== 1'b0) begin
            bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_single();
        int n0, e0, tf;
        tick(20);
        n0 = vq.size();
        e0 = ecnt;
        send_frame(8'h55, 1'b1, tf);
        tick(10);
        total++;
        if (vq.size() - n0 != 1) begin
            bad++; $display("FAIL single_count got=%0d want=1", vq.size() - n0);
        end
        total++;
        if (vq.size() <= n0 || vq[n0] !== 8'h55) begin
            bad++; $display("FAIL single_value got=%h want=55", (vq.size() > n0) ? vq[n0] : 8'hxx);
        end
        total++;
        if (vq.size() <= n0 || vt[n0] - tf != LAT) begin
            bad++; $display("FAIL single_latency got=%0d want=%0d",
                            (vq.size() > n0) ? vt[n0] - tf : -1, LAT);
        end
        total++;
        if (ecnt != e0) begin
            bad++; $display("FAIL single_no_err got=%0d want=0", ecnt - e0);
        end
        total++;
        if (rxbyte !== 8'h55 || busy !== 1'b0) begin
            bad++; $display("FAIL single_hold got=%h/%b want=55/0", rxbyte, busy);
        end
    endtask

    task automatic test_back_to_back();
        int n0, e0, tf0, tf;
        logic [7:0] d;
        n0 = vq.size();
        e0 = ecnt;
        tf0 = 0;
        for (int k = 0; k < 10; k++) begin
            d = 8'h30 + 8'(k);
            send_frame(d, 1'b1, tf);
            if (k == 0) tf0 = tf;
        end
        tick(10);
        total++;
        if (vq.size() - n0 != 10) begin
            bad++; $display("FAIL b2b_count got=%0d want=10", vq.size() - n0);
        end else begin
            for (int i = 0; i < 10; i++) begin
                d = 8'h30 + 8'(i);
                total++;
                if (vq[n0 + i] !== d) begin
                    bad++; $display("FAIL b2b_value[%0d] got=%h want=%h", i, vq[n0 + i], d);
                end
                if (i > 0) begin
                    total++;
                    if (vt[n0 + i] - vt[n0 + i - 1] != 10 * N) begin
                        bad++; $display("FAIL b2b_spacing[%0d] got=%0d want=%0d", i,
                                        vt[n0 + i] - vt[n0 + i - 1], 10 * N);
                    end
                end
            end
            total++;
            if (vt[n0] - tf0 != LAT) begin
                bad++; $display("FAIL b2b_latency got=%0d want=%0d", vt[n0] - tf0, LAT);
            end
        end
        total++;
        if (ecnt != e0) begin
            bad++; $display("FAIL b2b_no_err got=%0d want=0", ecnt - e0);
        end
    endtask

    task automatic test_glitch();
        int n0, e0, b0;
        tick(20);
        n0 = vq.size();
        e0 = ecnt;
        b0 = busy_cnt;
        rx = 1'b0;
        tick(10);
        rx = 1'b1;
        tick(100);
        total++;
        if (vq.size() != n0 || ecnt != e0) begin
            bad++; $display("FAIL glitch_no_strobe got=%0d/%0d want=0/0", vq.size() - n0, ecnt - e0);
        end
        total++;
        if (busy_cnt - b0 < 20 || busy_cnt - b0 > 30) begin
            bad++; $display("FAIL glitch_busy_len got=%0d want=20..30", busy_cnt - b0);
        end
        total++;
        if (busy !== 1'b0 || rxbyte !== 8'h39) begin
            bad++; $display("FAIL glitch_idle got=%b/%h want=0/39", busy, rxbyte);
        end
    endtask

    task automatic test_framing();
        int n0, e0, tf;
        n0 = vq.size();
        e0 = ecnt;
        send_frame(8'hA5, 1'b0, tf);
        tick(2000);
        total++;
        if (ecnt - e0 != 1) begin
            bad++; $display("FAIL ferr_count got=%0d want=1", ecnt - e0);
        end
        total++;
        if (et - tf != LAT) begin
            bad++; $display("FAIL ferr_latency got=%0d want=%0d", et - tf, LAT);
        end
        total++;
        if (vq.size() != n0 || rxbyte !== 8'h39) begin
            bad++; $display("FAIL ferr_keep got=%0d/%h want=0/39", vq.size() - n0, rxbyte);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL ferr_break_busy got=%b want=1", busy);
        end
        rx = 1'b1;
        tick(10);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL ferr_release got=%b want=0", busy);
        end
        send_frame(8'h3C, 1'b1, tf);
        tick(10);
        total++;
        if (vq.size() - n0 != 1 || vq[vq.size() - 1] !== 8'h3C || ecnt - e0 != 1) begin
            bad++; $display("FAIL ferr_next_frame got=%0d/%h want=1/3c", vq.size() - n0,
                            (vq.size() > 0) ? vq[vq.size() - 1] : 8'hxx);
        end
    endtask

    task automatic test_reset_mid();
        int n0, e0, tf;
        tick(20);
        n0 = vq.size();
        e0 = ecnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        rx    = 1'b1;
        total++;
        if (rxbyte !== 8'h00 || rxvalid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst_outputs got=%h/%b/%b/%b want=00/0/0/0",
                            rxbyte, rxvalid, frame_err, busy);
        end
        tick(600);
        total++;
        if (vq.size() != n0 || ecnt != e0) begin
            bad++; $display("FAIL midrst_no_strobe got=%0d/%0d want=0/0", vq.size() - n0, ecnt - e0);
        end
        send_frame(8'h81, 1'b1, tf);
        tick(10);
        total++;
        if (vq.size() - n0 != 1 || vq[vq.size() - 1] !== 8'h81) begin
            bad++; $display("FAIL midrst_next got=%0d/%h want=1/81", vq.size() - n0,
                            (vq.size() > 0) ? vq[vq.size() - 1] : 8'hxx);
        end
        total++;
        if (vq.size() <= n0 || vt[vt.size() - 1] - tf != LAT) begin
            bad++; $display("FAIL midrst_latency got=%0d want=%0d",
                            (vt.size() > 0) ? vt[vt.size() - 1] - tf : -1, LAT);
        end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority();
        int n0, e0, tf;
        logic [7:0] d;
        logic b;
        d = 8'hC3;
        tick(20);
        n0 = vq.size();
        e0 = ecnt;
        tf = cyc;
        for (int j = 0; j < 10 * N; j++) begin
            if (j < N) b = 1'b0;
            else if (j < 9 * N) b = d[(j / N) - 1];
            else b = 1'b1;
            if (j >= H + 2 && ((j - H - 2) % N) == 0) b = ~b;
            rx = b;
            tick(1);
        end
        rx = 1'b1;
        tick(10);
        total++;
        if (vq.size() - n0 != 1 || vq[vq.size() - 1] !== 8'hC3 || ecnt != e0) begin
            bad++; $display("FAIL maj_value got=%0d/%h want=1/c3", vq.size() - n0,
                            (vq.size() > 0) ? vq[vq.size() - 1] : 8'hxx);
        end
        total++;
        if (vq.size() <= n0 || vt[vt.size() - 1] - tf != LAT) begin
            bad++; $display("FAIL maj_latency got=%0d want=%0d",
                            (vt.size() > 0) ? vt[vt.size() - 1] - tf : -1, LAT);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        total++;
        if (both_cnt != 0) begin
            bad++; $display("FAIL strobe_exclusive got=%0d want=0", both_cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
